// File: rtl/mips_intc.sv
// CP0-style interrupt/exception controller: Status/Cause/EPC, prioritised req/ack, eret.
// Define INTC_VECTORED_EN for per-source handler vectors (else all use VEC_BASE).
module mips_intc #(
  parameter int N_IRQ = 6,
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] VEC_BASE = 'h180,
  parameter logic [WIDTH-1:0] VEC_STRIDE = 'h20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             trap,
  input  logic             we,
  input  logic [4:0]       addr,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic             int_ack,
  input  logic             eret,
  output logic             int_req,
  output logic [WIDTH-1:0] vector,
  output logic             exl,
  output logic             iv
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
`ifdef INTC_VECTORED_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERV
  } state_t;

  state_t r_state, w_nxt;

  logic             r_ie, r_exl, r_tp, r_req;
  logic [N_IRQ-1:0] r_im, r_ip;
  logic [4:0]       r_exc;
  logic [WIDTH-1:0] r_epc, r_vec;
  logic             r_wtrap;
  logic [IW-1:0]    r_widx;

  logic [N_IRQ-1:0] w_pend;
  logic             w_en, w_take, w_hit, w_still, w_ack;
  logic             w_wr_st, w_wr_epc;
  logic [IW-1:0]    w_idx;
  logic [WIDTH-1:0] w_vec_new, w_rd;

  assign w_pend   = r_ip & r_im;
  assign w_en     = (|w_pend) & r_ie & ~r_exl;
  assign w_take   = (r_tp | w_en) & ~r_exl;
  assign w_ack    = (r_state == S_REQ) & int_ack;
  assign w_wr_st  = we & (addr == 5'd12);
  assign w_wr_epc = we & (addr == 5'd14);

  // Lowest pending index wins among IRQs.
  always_comb begin
    w_idx = '0;
    w_hit = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_idx = IW'(i);
        w_hit = 1'b1;
      end
    end
  end

  always_comb begin
    if (r_tp || !w_hit || !VEC_EN)
      w_vec_new = VEC_BASE;
    else
      w_vec_new = VEC_BASE + (WIDTH'(w_idx) + WIDTH'(1)) * VEC_STRIDE;
  end

  // Latched winner must stay requestable, else the request is withdrawn.
  always_comb begin
    if (r_wtrap)
      w_still = r_tp & ~r_exl;
    else
      w_still = r_ip[r_widx] & r_im[r_widx] & r_ie & ~r_exl;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_take) w_nxt = S_REQ;
      S_REQ: begin
        if (int_ack) w_nxt = S_SERV;
        else if (!w_still) w_nxt = S_IDLE;
      end
      S_SERV: if (!r_exl || eret) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_wtrap <= 1'b0;
      r_widx  <= '0;
      r_vec   <= VEC_BASE;
    end else begin
      r_state <= w_nxt;
      r_req   <= (w_nxt == S_REQ);
      if (r_state == S_IDLE && w_take) begin
        r_wtrap <= r_tp;
        r_widx  <= w_idx;
        r_vec   <= w_vec_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ie  <= 1'b0;
      r_exl <= 1'b0;
      r_im  <= '0;
      r_ip  <= '0;
      r_tp  <= 1'b0;
      r_exc <= '0;
      r_epc <= '0;
    end else begin
      r_ip <= irq_in;
      r_tp <= (r_tp & ~(w_ack & r_wtrap)) | trap;
      if (w_wr_st) begin
        r_ie  <= wd[0];
        r_exl <= wd[1];
        r_im  <= wd[8 +: N_IRQ];
      end
      if (eret && r_exl) r_exl <= 1'b0;
      // Acceptance forces EXL even over a simultaneous Status write.
      if (w_ack) begin
        r_exl <= 1'b1;
        r_exc <= r_wtrap ? 5'd12 : 5'd0;
        r_epc <= pc_plus4;
      end else if (w_wr_epc) begin
        r_epc <= wd;
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (addr)
      5'd12: begin
        w_rd[0] = r_ie;
        w_rd[1] = r_exl;
        w_rd[8 +: N_IRQ] = r_im;
      end
      5'd13: begin
        w_rd[8 +: N_IRQ] = r_ip;
        w_rd[7] = r_tp;
        w_rd[6:2] = r_exc;
      end
      5'd14: w_rd = r_epc;
      default: w_rd = '0;
    endcase
  end

  assign rd      = w_rd;
  assign int_req = r_req;
  assign vector  = r_vec;
  assign exl     = r_exl;
  assign iv      = (|w_pend) | r_tp;

endmodule

// File: tb/tb_mips_intc.sv
// Self-checking bench for mips_intc: directed scenarios plus randomized
// IRQ patterns checked against a priority/vector reference model.
module tb_mips_intc;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq_in;
  logic        trap, we, int_ack, eret;
  logic [4:0]  addr;
  logic [31:0] wd, rd, pc_plus4, vector;
  logic        int_req, exl, iv;

  int nvec = 0;
  int nmis = 0;
  logic [31:0] t;

  always #5 clk = ~clk;

  mips_intc dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .trap(trap), .we(we),
    .addr(addr), .wd(wd), .rd(rd), .pc_plus4(pc_plus4),
    .int_ack(int_ack), .eret(eret), .int_req(int_req),
    .vector(vector), .exl(exl), .iv(iv)
  );

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] vec_of(input bit is_trap, input int idx);
`ifdef INTC_VECTORED_EN
    if (!is_trap) return 32'h180 + 32'(idx + 1) * 32'h20;
`endif
    return 32'h180;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    step();
    we = 1'b0;
  endtask

  task automatic rdreg(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd;
  endtask

  task automatic test_reset();
    rst = 1'b0; irq_in = '0; trap = 0; we = 0; int_ack = 0; eret = 0;
    addr = '0; wd = '0; pc_plus4 = '0;
    #12;
    for (int a = 12; a <= 14; a++) begin
      rdreg(5'(a), t);
      nvec++;
      if (t !== 32'h0) begin
        nmis++; $display("FAIL reset_reg%0d: got %h exp 0", a, t);
      end
    end
    nvec++;
    if ({int_req, exl, iv} !== 3'b000 || vector !== 32'h180) begin
      nmis++;
      $display("FAIL reset_out: req/exl/iv %b vec %h exp 000 180",
               {int_req, exl, iv}, vector);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_irq_basic();
    wr(5'd12, 32'h0000_0401);
    irq_in = 6'b000100;
    step();
    nvec++;
    if (int_req !== 1'b0) begin
      nmis++; $display("FAIL basic_lat1: got %b exp 0", int_req);
    end
    step();
    nvec++;
    if (int_req !== 1'b1 || vector !== vec_of(0, 2)) begin
      nmis++;
      $display("FAIL basic_req: req %b vec %h exp 1 %h", int_req, vector, vec_of(0, 2));
    end
    int_ack = 1; pc_plus4 = 32'h40;
    step();
    int_ack = 0;
    rdreg(5'd14, t);
    nvec++;
    if (t !== 32'h40 || exl !== 1'b1 || int_req !== 1'b0) begin
      nmis++; $display("FAIL basic_ack: epc %h exl %b req %b exp 40 1 0", t, exl, int_req);
    end
    rdreg(5'd13, t);
    nvec++;
    if (t[10] !== 1'b1 || t[6:2] !== 5'd0) begin
      nmis++; $display("FAIL basic_cause: got %h exp IP2=1 exc=0", t);
    end
    irq_in = '0; eret = 1;
    step();
    eret = 0;
    nvec++;
    if (exl !== 1'b0) begin
      nmis++; $display("FAIL basic_eret: exl %b exp 0", exl);
    end
    step();
  endtask

  task automatic test_priority();
    wr(5'd12, 32'h0000_3F01);
    irq_in = 6'b001010;
    step(); step();
    nvec++;
    if (int_req !== 1'b1 || vector !== vec_of(0, 1)) begin
      nmis++;
      $display("FAIL prio_vec: req %b vec %h exp 1 %h", int_req, vector, vec_of(0, 1));
    end
    int_ack = 1; pc_plus4 = 32'h80;
    step();
    int_ack = 0; irq_in = '0; eret = 1;
    step();
    eret = 0;
    step();
  endtask

  task automatic test_trap();
    wr(5'd12, 32'h0);
    trap = 1;
    step();
    trap = 0;
    rdreg(5'd13, t);
    nvec++;
    if (t[7] !== 1'b1 || int_req !== 1'b0) begin
      nmis++; $display("FAIL trap_tp: cause %h req %b exp TP=1 req 0", t, int_req);
    end
    step();
    nvec++;
    if (int_req !== 1'b1 || vector !== 32'h180) begin
      nmis++; $display("FAIL trap_req: req %b vec %h exp 1 180", int_req, vector);
    end
    int_ack = 1; pc_plus4 = 32'h44;
    step();
    int_ack = 0;
    rdreg(5'd13, t);
    nvec++;
    if (t[6:2] !== 5'd12 || t[7] !== 1'b0 || exl !== 1'b1) begin
      nmis++; $display("FAIL trap_ack: cause %h exl %b exp exc=12 TP=0 exl=1", t, exl);
    end
    eret = 1;
    step();
    eret = 0;
    step();
    nvec++;
    if (exl !== 1'b0 || int_req !== 1'b0) begin
      nmis++; $display("FAIL trap_eret: exl %b req %b exp 0 0", exl, int_req);
    end
  endtask

  task automatic test_withdraw();
    logic [31:0] epc0;
    rdreg(5'd14, epc0);
    wr(5'd12, 32'h0000_0401);
    irq_in = 6'b000100;
    step(); step();
    nvec++;
    if (int_req !== 1'b1) begin
      nmis++; $display("FAIL wd_req: got %b exp 1", int_req);
    end
    wr(5'd12, 32'h0000_0001);
    step();
    rdreg(5'd14, t);
    nvec++;
    if (int_req !== 1'b0 || t !== epc0 || exl !== 1'b0) begin
      nmis++;
      $display("FAIL wd_drop: req %b epc %h exl %b exp 0 %h 0", int_req, t, exl, epc0);
    end
    irq_in = '0;
    step();
  endtask

  task automatic test_service_block();
    wr(5'd12, 32'h0000_3F01);
    irq_in = 6'b000100;
    step(); step();
    int_ack = 1; pc_plus4 = 32'h100;
    step();
    int_ack = 0;
    irq_in = 6'b000101;
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++;
      if (int_req !== 1'b0) begin
        nmis++; $display("FAIL svc_block%0d: req %b exp 0", i, int_req);
      end
    end
    eret = 1;
    step();
    eret = 0;
    nvec++;
    if (int_req !== 1'b0) begin
      nmis++; $display("FAIL svc_eret_cycle: req %b exp 0", int_req);
    end
    step();
    nvec++;
    if (int_req !== 1'b1 || vector !== vec_of(0, 0)) begin
      nmis++;
      $display("FAIL svc_after: req %b vec %h exp 1 %h", int_req, vector, vec_of(0, 0));
    end
    int_ack = 1; pc_plus4 = 32'h104;
    step();
    int_ack = 0;
    rst = 1'b0;
    #1;
    nvec++;
    if ({int_req, exl, iv} !== 3'b000 || vector !== 32'h180) begin
      nmis++;
      $display("FAIL svc_rst_out: req/exl/iv %b vec %h exp 000 180",
               {int_req, exl, iv}, vector);
    end
    for (int a = 12; a <= 14; a++) begin
      rdreg(5'(a), t);
      nvec++;
      if (t !== 32'h0) begin
        nmis++; $display("FAIL svc_rst_reg%0d: got %h exp 0", a, t);
      end
    end
    irq_in = '0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_edges();
    logic [31:0] epc0;
    wr(5'd12, 32'h0000_0401);
    rdreg(5'd14, epc0);
    int_ack = 1; pc_plus4 = 32'hDEAD_0000;
    step();
    int_ack = 0;
    rdreg(5'd14, t);
    nvec++;
    if (exl !== 1'b0 || t !== epc0 || int_req !== 1'b0) begin
      nmis++; $display("FAIL edge_stray_ack: exl %b epc %h exp 0 %h", exl, t, epc0);
    end
    eret = 1;
    step();
    eret = 0;
    rdreg(5'd12, t);
    nvec++;
    if (t !== 32'h401 || exl !== 1'b0) begin
      nmis++; $display("FAIL edge_stray_eret: status %h exp 401", t);
    end
    irq_in = 6'b000100;
    step(); step();
    we = 1; addr = 5'd12; wd = 32'h0000_0801;
    int_ack = 1; pc_plus4 = 32'h200;
    step();
    we = 0; int_ack = 0;
    rdreg(5'd12, t);
    nvec++;
    if (t !== 32'h803 || exl !== 1'b1) begin
      nmis++; $display("FAIL edge_wr_ack: status %h exl %b exp 803 1", t, exl);
    end
    eret = 1;
    step();
    eret = 0;
    wr(5'd12, 32'h0000_0401);
    step();
    nvec++;
    if (int_req !== 1'b1) begin
      nmis++; $display("FAIL edge_re_req: req %b exp 1", int_req);
    end
    int_ack = 1; trap = 1; pc_plus4 = 32'h300;
    step();
    int_ack = 0; trap = 0; irq_in = '0;
    rdreg(5'd13, t);
    nvec++;
    if (t[7] !== 1'b1 || t[6:2] !== 5'd0 || exl !== 1'b1 || int_req !== 1'b0) begin
      nmis++; $display("FAIL edge_trap_ack: cause %h exl %b exp TP=1 exc=0 exl=1", t, exl);
    end
    eret = 1;
    step();
    eret = 0;
    step();
    nvec++;
    if (int_req !== 1'b1 || vector !== 32'h180) begin
      nmis++; $display("FAIL edge_trap_after: req %b vec %h exp 1 180", int_req, vector);
    end
    int_ack = 1;
    step();
    int_ack = 0;
    rdreg(5'd13, t);
    nvec++;
    if (t[6:2] !== 5'd12 || t[7] !== 1'b0) begin
      nmis++; $display("FAIL edge_trap_svc: cause %h exp exc=12 TP=0", t);
    end
    irq_in = 6'b000100;
    wr(5'd12, 32'h0000_0401);
    begin
      bit seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
        step();
        if (int_req === 1'b1) seen = 1;
      end
      nvec++;
      if (!seen || exl !== 1'b0) begin
        nmis++; $display("FAIL edge_sw_exl: seen %b exl %b exp 1 0", seen, exl);
      end
    end
    int_ack = 1;
    step();
    int_ack = 0; irq_in = '0; eret = 1;
    step();
    eret = 0;
    step();
  endtask

  task automatic test_random();
    logic [5:0]  irq, im, hit;
    logic [31:0] pc;
    for (int n = 0; n < 24; n++) begin
      irq = 6'($urandom_range(1, 63));
      im  = 6'($urandom_range(0, 63));
      pc  = $urandom & 32'hFFFF_FFFC;
      hit = irq & im;
      wr(5'd12, {18'h0, im, 8'h01});
      irq_in = irq;
      step();
      nvec++;
      if (iv !== (hit != 0) || int_req !== 1'b0) begin
        nmis++;
        $display("FAIL rnd_iv%0d: iv %b req %b exp %b 0", n, iv, int_req, hit != 0);
      end
      step();
      nvec++;
      if (int_req !== (hit != 0)) begin
        nmis++; $display("FAIL rnd_req%0d: got %b exp %b", n, int_req, hit != 0);
      end
      if (hit != 0) begin
        nvec++;
        if (vector !== vec_of(0, lowest(hit))) begin
          nmis++;
          $display("FAIL rnd_vec%0d: got %h exp %h", n, vector, vec_of(0, lowest(hit)));
        end
        int_ack = 1; pc_plus4 = pc;
        step();
        int_ack = 0;
        rdreg(5'd14, t);
        nvec++;
        if (t !== pc || exl !== 1'b1) begin
          nmis++; $display("FAIL rnd_epc%0d: epc %h exl %b exp %h 1", n, t, exl, pc);
        end
        rdreg(5'd13, t);
        nvec++;
        if (t[13:8] !== irq || t[6:2] !== 5'd0) begin
          nmis++; $display("FAIL rnd_cause%0d: got %h exp IP %h exc 0", n, t, irq);
        end
        eret = 1;
        step();
        eret = 0;
      end
      irq_in = '0;
      step();
      step();
    end
  endtask

  initial begin
    test_reset();
    test_irq_basic();
    test_priority();
    test_trap();
    test_withdraw();
    test_service_block();
    test_edges();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
